slew_rate_limiter_mc: RTL and testbench

//  Multi-channel, parametrised slew-rate limiter. Each channel holds a target and
//  an output; on every update tick the output moves toward its target by at most

---
 rtl/slew_rate_limiter_mc.sv | 111 +++++++++++
 tb/tb_slew_rate_limiter_mc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/slew_rate_limiter_mc.sv
// Multi-channel slew-rate limiter: each channel's output ramps toward its target
// by at most rise_step / fall_step per update tick, saturating at the target.
module slew_rate_limiter_mc #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [CH_W-1:0]           in_ch,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [STEP_W-1:0]         rise_step,
  input  logic [STEP_W-1:0]         fall_step,
  input  logic                      bypass,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       settled,
  output logic                      tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0]          cnt_r;
  logic                      fire_s;
  logic                      wr_s;
  logic                      tick_r;
  logic [WIDTH-1:0]          target_r [CHANNELS];
  logic [WIDTH-1:0]          next_s   [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] data_out_r;
  logic [CHANNELS-1:0]       settled_s;

  assign fire_s = enable && (cnt_r == CNT_W'(PRESCALE - 1));
  // Out-of-range channel indices are dropped rather than aliased onto a real channel.
  assign wr_s   = in_valid && ({{(32-CH_W){1'b0}}, in_ch} < 32'(CHANNELS));

  // Prescale counter: advances only while enabled, wraps at the firing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (fire_s) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Per-channel step computation; differences taken in WIDTH+1 bits to avoid wrap.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      logic [WIDTH-1:0] o;
      logic [WIDTH-1:0] t;
      logic [WIDTH:0]   diff;
      o    = data_out_r[i*WIDTH +: WIDTH];
      t    = target_r[i];
      diff = '0;
      next_s[i] = o;
      if (bypass) begin
        next_s[i] = t;
      end else if (o < t) begin
        diff = {1'b0, t} - {1'b0, o};
        next_s[i] = (diff <= (WIDTH+1)'(rise_step)) ? t : o + WIDTH'(rise_step);
      end else if (o > t) begin
        diff = {1'b0, o} - {1'b0, t};
        next_s[i] = (diff <= (WIDTH+1)'(fall_step)) ? t : o - WIDTH'(fall_step);
      end else begin
        next_s[i] = o;
      end
    end
  end

  // Target registers; the update above always sees the pre-write target.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        target_r[i] <= '0;
      end else if (wr_s && (in_ch == CH_W'(i))) begin
        target_r[i] <= in_data;
      end
    end
  end

  // Output registers and tick pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= '0;
      tick_r     <= 1'b0;
    end else begin
      tick_r <= fire_s;
      if (fire_s) begin
        for (int i = 0; i < CHANNELS; i++) begin
          data_out_r[i*WIDTH +: WIDTH] <= next_s[i];
        end
      end
    end
  end

  // Settled flags compare registered outputs against registered targets.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      settled_s[i] = (data_out_r[i*WIDTH +: WIDTH] == target_r[i]);
    end
  end

  assign data_out = data_out_r;
  assign settled  = settled_s;
  assign tick     = tick_r;

endmodule

// File: tb/tb_slew_rate_limiter_mc.sv
// Directed bench for slew_rate_limiter_mc: vector table plus hand-written ramps
// for prescale/enable, asymmetric fall, same-cycle write and mid-ramp reset.
module tb_slew_rate_limiter_mc;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, bypass;
  logic [2:0]  in_ch;
  logic [7:0]  in_data;
  logic [3:0]  rise_step, fall_step;
  logic [31:0] data_out, data_out4;
  logic [3:0]  settled, settled4;
  logic        tick, tick4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slew_rate_limiter_mc #(.WIDTH(8), .STEP_W(4), .CHANNELS(4), .PRESCALE(1), .CH_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .rise_step(rise_step), .fall_step(fall_step), .bypass(bypass),
    .data_out(data_out), .settled(settled), .tick(tick));

  slew_rate_limiter_mc #(.WIDTH(8), .STEP_W(4), .CHANNELS(4), .PRESCALE(4), .CH_W(3)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .rise_step(rise_step), .fall_step(fall_step), .bypass(bypass),
    .data_out(data_out4), .settled(settled4), .tick(tick4));

  typedef struct {
    logic        rst, en, vld;
    logic [2:0]  ch;
    logic [7:0]  d;
    logic [3:0]  rs, fs;
    logic        byp;
    logic [31:0] eo;
    logic [3:0]  es;
    logic        et;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, en, vld, input logic [2:0] ch, input logic [7:0] d,
                     input logic [3:0] rs, fs, input logic byp,
                     input logic [31:0] eo, input logic [3:0] es, input logic et);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.ch = ch; v.d = d;
    v.rs = rs; v.fs = fs; v.byp = byp; v.eo = eo; v.es = es; v.et = et;
    vq.push_back(v);
  endtask

  task automatic drv(input logic rst, en, vld, input logic [2:0] ch, input logic [7:0] d,
                     input logic [3:0] rs, fs, input logic byp);
    reset = rst; enable = en; in_valid = vld; in_ch = ch; in_data = d;
    rise_step = rs; fall_step = fs; bypass = byp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int mout;
    int k;
    logic en_c;
    logic fire;
    drv(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'd15, 4'd15, 1'b0);

    // rst en vld ch d rs fs byp | data_out settled tick
    add(1,0,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_0000,4'hF,0);
    add(0,0,1,3'd0,8'd60, 4'd15,4'd15,0, 32'h0000_0000,4'hE,0);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_000F,4'hE,1);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_001E,4'hE,1);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_002D,4'hE,1);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_003C,4'hF,1);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_003C,4'hF,1);
    add(0,0,1,3'd1,8'd250,4'd15,4'd15,0, 32'h0000_003C,4'hD,0);
    add(0,0,1,3'd2,8'd10, 4'd15,4'd15,0, 32'h0000_003C,4'h9,0);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,1, 32'h000A_FA3C,4'hF,1);
    add(0,0,1,3'd1,8'd255,4'd15,4'd15,0, 32'h000A_FA3C,4'hD,0);
    add(0,0,1,3'd2,8'd0,  4'd15,4'd15,0, 32'h000A_FA3C,4'h9,0);
    add(0,1,0,3'd0,8'd0,  4'd15,4'd15,0, 32'h0000_FF3C,4'hF,1);
    add(0,0,1,3'd3,8'd9,  4'd0, 4'd15,0, 32'h0000_FF3C,4'h7,0);
    add(0,1,0,3'd0,8'd0,  4'd0, 4'd15,0, 32'h0000_FF3C,4'h7,1);
    add(0,1,0,3'd0,8'd0,  4'd0, 4'd15,0, 32'h0000_FF3C,4'h7,1);
    add(0,0,1,3'd5,8'd77, 4'd0, 4'd15,0, 32'h0000_FF3C,4'h7,0);
    add(0,1,0,3'd0,8'd0,  4'd0, 4'd15,1, 32'h0900_FF3C,4'hF,1);

    for (int i = 0; i < vq.size(); i++) begin
      drv(vq[i].rst, vq[i].en, vq[i].vld, vq[i].ch, vq[i].d, vq[i].rs, vq[i].fs, vq[i].byp);
      step();
      chk($sformatf("vec%0d data_out", i), data_out, vq[i].eo);
      chk($sformatf("vec%0d settled", i), {28'd0, settled}, {28'd0, vq[i].es});
      chk($sformatf("vec%0d tick", i), {31'd0, tick}, {31'd0, vq[i].et});
    end

    // Asymmetric fall: 200 -> 100 with fall_step 7 takes 15 ticks.
    drv(1,0,0,3'd0,8'd0,4'd15,4'd7,0);     step();
    drv(0,0,1,3'd0,8'd200,4'd15,4'd7,0);   step();
    drv(0,1,0,3'd0,8'd0,4'd15,4'd7,1);     step();
    chk("fall start", data_out, 32'd200);
    drv(0,0,1,3'd0,8'd100,4'd15,4'd7,0);   step();
    for (int t = 1; t <= 15; t++) begin
      mout = 200 - 7 * t;
      if (mout < 100) mout = 100;
      drv(0,1,0,3'd0,8'd0,4'd15,4'd7,0);   step();
      chk($sformatf("fall t%0d", t), {24'd0, data_out[7:0]}, 32'(mout));
      chk($sformatf("fall settled t%0d", t), {31'd0, settled[0]}, {31'd0, (mout == 100)});
    end

    // Same-cycle write and tick: the tick still uses the old target 20.
    drv(1,0,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    drv(0,0,1,3'd0,8'd20,4'd15,4'd15,0);   step();
    drv(0,1,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    chk("samecyc pre", data_out, 32'd15);
    drv(0,1,1,3'd0,8'd40,4'd15,4'd15,0);   step();
    chk("samecyc old target", data_out, 32'd20);
    chk("samecyc settled", {28'd0, settled}, 32'hE);
    drv(0,1,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    chk("samecyc next", data_out, 32'd35);
    step();
    chk("samecyc final", data_out, 32'd40);

    // Reset mid-ramp at 30 toward 60.
    drv(1,0,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    drv(0,0,1,3'd0,8'd60,4'd15,4'd15,0);   step();
    drv(0,1,0,3'd0,8'd0,4'd15,4'd15,0);    step(); step();
    chk("midramp 30", data_out, 32'd30);
    drv(1,1,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    chk("reset out", data_out, 32'd0);
    chk("reset settled", {28'd0, settled}, 32'hF);
    chk("reset tick", {31'd0, tick}, 32'd0);
    drv(0,1,0,3'd0,8'd0,4'd15,4'd15,0);    step();
    chk("post reset out", data_out, 32'd0);
    chk("post reset settled", {28'd0, settled}, 32'hF);
    chk("post reset tick", {31'd0, tick}, 32'd1);

    // PRESCALE=4 instance: +5 every 4th enabled cycle, enable low freezes counter.
    drv(1,0,0,3'd0,8'd0,4'd5,4'd15,0);     step();
    drv(0,0,1,3'd0,8'd20,4'd5,4'd15,0);    step();
    chk("ps settled after write", {28'd0, settled4}, 32'hE);
    mout = 0;
    k = 0;
    for (int c = 0; c < 26; c++) begin
      en_c = !(c >= 6 && c < 12);
      drv(0,en_c,0,3'd0,8'd0,4'd5,4'd15,0); step();
      fire = 1'b0;
      if (en_c) begin
        k++;
        fire = (k % 4 == 0);
        if (fire && mout < 20) mout += 5;
      end
      chk($sformatf("ps out c%0d", c), {24'd0, data_out4[7:0]}, 32'(mout));
      chk($sformatf("ps tick c%0d", c), {31'd0, tick4}, {31'd0, fire});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
